// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: forwarding codes,
// FSM encodings, parameter defaults and the control-output bundle patterns.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] HZ_RUN    = 2'd0;
  localparam logic [1:0] HZ_MDBUSY = 2'd1;
  localparam logic [1:0] HZ_HALT   = 2'd2;

  localparam int MD_CYCLES_DEFAULT   = 32;
  localparam int MEM_TIMEOUT_DEFAULT = 255;

  typedef struct packed {
    logic pcen;
    logic stallD;
    logic stallE;
    logic stallM;
    logic flushD;
    logic flushE;
    logic flushM;
    logic flushW;
    logic md_done;
    logic mem_err;
  } hz_ctrl_t;

  // Field order: pcen, stallD/E/M, flushD/E/M/W, md_done, mem_err
  localparam hz_ctrl_t CTRL_RUN      = 10'b1_000_0000_0_0;
  localparam hz_ctrl_t CTRL_RESET    = 10'b0_000_1111_0_0;
  localparam hz_ctrl_t CTRL_LOAD_USE = 10'b0_100_0100_0_0;
  localparam hz_ctrl_t CTRL_REDIRECT = 10'b1_000_1100_0_0;
  localparam hz_ctrl_t CTRL_MD_STALL = 10'b0_110_0010_0_0;
  localparam hz_ctrl_t CTRL_MD_DONE  = 10'b1_000_0000_1_0;
  localparam hz_ctrl_t CTRL_MEM_WAIT = 10'b0_111_0001_0_0;
  localparam hz_ctrl_t CTRL_HALT     = 10'b0_111_0000_0_1;

endpackage

// File: rtl/fwd_sel.sv
// EX operand forwarding select for one source register; the M stage
// result takes priority over W, and x0 is never forwarded.
module fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] i_rsE,
  input  logic [4:0] i_rdM,
  input  logic       i_regwriteM,
  input  logic [4:0] i_rdW,
  input  logic       i_regwriteW,
  output logic [1:0] o_fwd
);

  always_comb begin
    o_fwd = FWD_RF;
    if (i_regwriteM && (i_rdM != 5'd0) && (i_rdM == i_rsE)) begin
      o_fwd = FWD_M;
    end else if (i_regwriteW && (i_rdW != 5'd0) && (i_rdW == i_rsE)) begin
      o_fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, redirect flush,
// multi-cycle mul/div stall and data-memory wait with timeout halt.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_CYCLES   = MD_CYCLES_DEFAULT,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs1D,
  input  logic [4:0] rs2D,
  input  logic [4:0] rs1E,
  input  logic [4:0] rs2E,
  input  logic [4:0] rdE,
  input  logic       memreadE,
  input  logic [4:0] rdM,
  input  logic [4:0] rdW,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       jumpE,
  input  logic       mdstartE,
  input  logic       dmem_waitM,
  output logic       pcen,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       flushW,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       md_done,
  output logic       mem_err
);

  localparam logic [7:0] MD_LOAD    = 8'(MD_CYCLES - 1);
  localparam logic [8:0] WAIT_LIMIT = 9'(MEM_TIMEOUT);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [7:0] r_mdcnt;
  logic [7:0] w_mdcnt_nxt;
  logic [7:0] r_waitcnt;
  logic [7:0] w_waitcnt_nxt;
  logic [8:0] w_waitcnt_inc;
  logic       w_load_use;
  hz_ctrl_t   w_ctrl;

  assign w_load_use    = memreadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
  assign w_waitcnt_inc = {1'b0, r_waitcnt} + 9'd1;

  always_comb begin
    w_state_nxt   = r_state;
    w_mdcnt_nxt   = r_mdcnt;
    w_waitcnt_nxt = 8'd0;
    w_ctrl        = CTRL_RUN;
    case (r_state)
      HZ_HALT: begin
        w_ctrl        = CTRL_HALT;
        w_waitcnt_nxt = r_waitcnt;
      end
      default: begin
        if (dmem_waitM) begin
          // Memory wait freezes the whole pipe, including an mul/div countdown
          w_ctrl        = CTRL_MEM_WAIT;
          w_waitcnt_nxt = w_waitcnt_inc[7:0];
          if (w_waitcnt_inc == WAIT_LIMIT) begin
            w_state_nxt = HZ_HALT;
          end
        end else if (r_state == HZ_MDBUSY) begin
          if (r_mdcnt != 8'd0) begin
            w_ctrl      = CTRL_MD_STALL;
            w_mdcnt_nxt = r_mdcnt - 8'd1;
          end else begin
            w_ctrl      = CTRL_MD_DONE;
            w_state_nxt = HZ_RUN;
          end
        end else if (mdstartE) begin
          // The mul/div occupies EX, so it outranks a redirect or load-use
          w_ctrl      = CTRL_MD_STALL;
          w_state_nxt = HZ_MDBUSY;
          w_mdcnt_nxt = MD_LOAD;
        end else if (jumpE) begin
          w_ctrl = CTRL_REDIRECT;
        end else if (w_load_use) begin
          w_ctrl = CTRL_LOAD_USE;
        end
      end
    endcase
    if (reset) begin
      w_ctrl = CTRL_RESET;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= HZ_RUN;
      r_mdcnt   <= 8'd0;
      r_waitcnt <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_mdcnt   <= w_mdcnt_nxt;
      r_waitcnt <= w_waitcnt_nxt;
    end
  end

  assign pcen    = w_ctrl.pcen;
  assign stallD  = w_ctrl.stallD;
  assign stallE  = w_ctrl.stallE;
  assign stallM  = w_ctrl.stallM;
  assign flushD  = w_ctrl.flushD;
  assign flushE  = w_ctrl.flushE;
  assign flushM  = w_ctrl.flushM;
  assign flushW  = w_ctrl.flushW;
  assign md_done = w_ctrl.md_done;
  assign mem_err = w_ctrl.mem_err;

  fwd_sel u_fwd_a (
    .i_rsE       (rs1E),
    .i_rdM       (rdM),
    .i_regwriteM (regwriteM),
    .i_rdW       (rdW),
    .i_regwriteW (regwriteW),
    .o_fwd       (forwardAE)
  );

  fwd_sel u_fwd_b (
    .i_rsE       (rs2E),
    .i_rdM       (rdM),
    .i_regwriteM (regwriteM),
    .i_rdW       (rdW),
    .i_regwriteW (regwriteW),
    .o_fwd       (forwardBE)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MD_CYCLES=4, MEM_TIMEOUT=3): each
// scenario queues per-cycle stimulus with its expected output vector.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       memreadE, regwriteM, regwriteW, jumpE, mdstartE, dmem_waitM;
  logic       pcen, stallD, stallE, stallM;
  logic       flushD, flushE, flushM, flushW;
  logic [1:0] forwardAE, forwardBE;
  logic       md_done, mem_err;

  typedef struct packed {
    logic       reset;
    logic [4:0] rs1D;
    logic [4:0] rs2D;
    logic [4:0] rs1E;
    logic [4:0] rs2E;
    logic [4:0] rdE;
    logic [4:0] rdM;
    logic [4:0] rdW;
    logic       memreadE;
    logic       regwriteM;
    logic       regwriteW;
    logic       jumpE;
    logic       mdstartE;
    logic       dmem_waitM;
  } stim_t;

  // Vector: pcen, stallD/E/M, flushD/E/M/W, md_done, mem_err, fwdA, fwdB
  localparam logic [13:0] E_RUN   = 14'b1_000_0000_00_00_00;
  localparam logic [13:0] E_RESET = 14'b0_000_1111_00_00_00;
  localparam logic [13:0] E_LU    = 14'b0_100_0100_00_00_00;
  localparam logic [13:0] E_REDIR = 14'b1_000_1100_00_00_00;
  localparam logic [13:0] E_MD    = 14'b0_110_0010_00_00_00;
  localparam logic [13:0] E_DONE  = 14'b1_000_0000_10_00_00;
  localparam logic [13:0] E_WAIT  = 14'b0_111_0001_00_00_00;
  localparam logic [13:0] E_HALT  = 14'b0_111_0000_01_00_00;

  logic [13:0] obs;
  assign obs = {pcen, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
                md_done, mem_err, forwardAE, forwardBE};

  int          checks = 0;
  int          errors = 0;
  stim_t       pend_s[$];
  logic [13:0] pend_e[$];
  logic [13:0] exp_q[$];

  hazard_ctrl #(.MD_CYCLES(4), .MEM_TIMEOUT(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .rs1D       (rs1D),
    .rs2D       (rs2D),
    .rs1E       (rs1E),
    .rs2E       (rs2E),
    .rdE        (rdE),
    .memreadE   (memreadE),
    .rdM        (rdM),
    .rdW        (rdW),
    .regwriteM  (regwriteM),
    .regwriteW  (regwriteW),
    .jumpE      (jumpE),
    .mdstartE   (mdstartE),
    .dmem_waitM (dmem_waitM),
    .pcen       (pcen),
    .stallD     (stallD),
    .stallE     (stallE),
    .stallM     (stallM),
    .flushD     (flushD),
    .flushE     (flushE),
    .flushM     (flushM),
    .flushW     (flushW),
    .forwardAE  (forwardAE),
    .forwardBE  (forwardBE),
    .md_done    (md_done),
    .mem_err    (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply(input stim_t s);
    reset      = s.reset;
    rs1D       = s.rs1D;
    rs2D       = s.rs2D;
    rs1E       = s.rs1E;
    rs2E       = s.rs2E;
    rdE        = s.rdE;
    rdM        = s.rdM;
    rdW        = s.rdW;
    memreadE   = s.memreadE;
    regwriteM  = s.regwriteM;
    regwriteW  = s.regwriteW;
    jumpE      = s.jumpE;
    mdstartE   = s.mdstartE;
    dmem_waitM = s.dmem_waitM;
  endtask

  task automatic add(input stim_t s, input logic [13:0] e);
    pend_s.push_back(s);
    pend_e.push_back(e);
  endtask

  task automatic test_reset();
    stim_t s;
    logic [13:0] want;
    int cyc = 0;
    s = '0; s.reset = 1'b1;
    add(s, E_RESET);
    s.regwriteM = 1'b1; s.rdM = 5'd5; s.rs1E = 5'd5;
    add(s, E_RESET | 14'b10_00);
    s = '0;
    add(s, E_RUN);
    add(s, E_RUN);
    while (pend_s.size() > 0) begin
      @(posedge clk); #1;
      apply(pend_s.pop_front());
      exp_q.push_back(pend_e.pop_front());
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL test_reset cycle %0d: got %b expected %b", cyc, obs, want);
      end else $display("ok   test_reset cycle %0d: %b", cyc, obs);
      cyc++;
    end
  endtask

  task automatic test_forwarding();
    stim_t s;
    logic [13:0] want;
    int cyc = 0;
    s = '0; s.regwriteM = 1'b1; s.rdM = 5'd5; s.regwriteW = 1'b1; s.rdW = 5'd5; s.rs1E = 5'd5;
    add(s, E_RUN | 14'b10_00);
    s.rdM = 5'd0;
    add(s, E_RUN | 14'b01_00);
    s = '0; s.regwriteM = 1'b1; s.rdM = 5'd3; s.regwriteW = 1'b1; s.rdW = 5'd3; s.rs2E = 5'd3;
    add(s, E_RUN | 14'b00_10);
    s.regwriteM = 1'b0; s.rs1E = 5'd3;
    add(s, E_RUN | 14'b01_01);
    s = '0; s.regwriteM = 1'b1; s.regwriteW = 1'b1;
    add(s, E_RUN);
    s = '0; s.regwriteM = 1'b1; s.rdM = 5'd9; s.rdW = 5'd9; s.rs1E = 5'd9; s.rs2E = 5'd9;
    add(s, E_RUN | 14'b10_10);
    s = '0; s.regwriteW = 1'b1; s.rdW = 5'd12; s.rdM = 5'd12; s.rs2E = 5'd12;
    add(s, E_RUN | 14'b00_01);
    while (pend_s.size() > 0) begin
      @(posedge clk); #1;
      apply(pend_s.pop_front());
      exp_q.push_back(pend_e.pop_front());
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL test_forwarding cycle %0d: got %b expected %b", cyc, obs, want);
      end else $display("ok   test_forwarding cycle %0d: %b", cyc, obs);
      cyc++;
    end
  endtask

  task automatic test_load_use();
    stim_t s;
    logic [13:0] want;
    int cyc = 0;
    s = '0; s.memreadE = 1'b1; s.rdE = 5'd7; s.rs2D = 5'd7;
    add(s, E_LU);
    s = '0;
    add(s, E_RUN);
    s = '0; s.memreadE = 1'b1; s.rdE = 5'd7; s.rs1D = 5'd7;
    add(s, E_LU);
    s = '0; s.memreadE = 1'b1;
    add(s, E_RUN);
    s = '0; s.memreadE = 1'b1; s.rdE = 5'd7; s.rs2D = 5'd7; s.jumpE = 1'b1;
    add(s, E_REDIR);
    s = '0; s.jumpE = 1'b1;
    add(s, E_REDIR);
    s = '0; s.rdE = 5'd7; s.rs1D = 5'd7;
    add(s, E_RUN);
    while (pend_s.size() > 0) begin
      @(posedge clk); #1;
      apply(pend_s.pop_front());
      exp_q.push_back(pend_e.pop_front());
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL test_load_use cycle %0d: got %b expected %b", cyc, obs, want);
      end else $display("ok   test_load_use cycle %0d: %b", cyc, obs);
      cyc++;
    end
  endtask

  task automatic test_mul_div();
    stim_t s;
    logic [13:0] want;
    int cyc = 0;
    s = '0; s.mdstartE = 1'b1;
    add(s, E_MD);
    add(s, E_MD);
    s.jumpE = 1'b1;
    add(s, E_MD);
    s.jumpE = 1'b0; s.memreadE = 1'b1; s.rdE = 5'd7; s.rs1D = 5'd7;
    add(s, E_MD);
    s = '0; s.mdstartE = 1'b1;
    add(s, E_DONE);
    s = '0;
    add(s, E_RUN);
    while (pend_s.size() > 0) begin
      @(posedge clk); #1;
      apply(pend_s.pop_front());
      exp_q.push_back(pend_e.pop_front());
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL test_mul_div cycle %0d: got %b expected %b", cyc, obs, want);
      end else $display("ok   test_mul_div cycle %0d: %b", cyc, obs);
      cyc++;
    end
  endtask

  task automatic test_md_wait();
    stim_t s;
    logic [13:0] want;
    int cyc = 0;
    s = '0; s.mdstartE = 1'b1;
    add(s, E_MD);
    s = '0; s.dmem_waitM = 1'b1;
    add(s, E_WAIT);
    s.jumpE = 1'b1;
    add(s, E_WAIT);
    s = '0;
    add(s, E_MD);
    add(s, E_MD);
    add(s, E_MD);
    add(s, E_DONE);
    add(s, E_RUN);
    while (pend_s.size() > 0) begin
      @(posedge clk); #1;
      apply(pend_s.pop_front());
      exp_q.push_back(pend_e.pop_front());
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL test_md_wait cycle %0d: got %b expected %b", cyc, obs, want);
      end else $display("ok   test_md_wait cycle %0d: %b", cyc, obs);
      cyc++;
    end
  endtask

  task automatic test_mem_timeout();
    stim_t s;
    logic [13:0] want;
    int cyc = 0;
    s = '0; s.dmem_waitM = 1'b1;
    add(s, E_WAIT);
    add(s, E_WAIT);
    s = '0;
    add(s, E_RUN);
    s.dmem_waitM = 1'b1;
    add(s, E_WAIT);
    add(s, E_WAIT);
    s = '0;
    add(s, E_RUN);
    s.dmem_waitM = 1'b1;
    add(s, E_WAIT);
    add(s, E_WAIT);
    add(s, E_WAIT);
    add(s, E_HALT);
    s = '0; s.jumpE = 1'b1; s.mdstartE = 1'b1;
    add(s, E_HALT);
    s = '0; s.regwriteM = 1'b1; s.rdM = 5'd4; s.rs1E = 5'd4;
    add(s, E_HALT | 14'b10_00);
    s = '0; s.reset = 1'b1;
    add(s, E_RESET);
    s = '0;
    add(s, E_RUN);
    while (pend_s.size() > 0) begin
      @(posedge clk); #1;
      apply(pend_s.pop_front());
      exp_q.push_back(pend_e.pop_front());
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL test_mem_timeout cycle %0d: got %b expected %b", cyc, obs, want);
      end else $display("ok   test_mem_timeout cycle %0d: %b", cyc, obs);
      cyc++;
    end
  endtask

  task automatic test_reset_mdbusy();
    stim_t s;
    logic [13:0] want;
    int cyc = 0;
    s = '0; s.mdstartE = 1'b1;
    add(s, E_MD);
    s = '0;
    add(s, E_MD);
    s.reset = 1'b1;
    add(s, E_RESET);
    s = '0;
    add(s, E_RUN);
    add(s, E_RUN);
    add(s, E_RUN);
    while (pend_s.size() > 0) begin
      @(posedge clk); #1;
      apply(pend_s.pop_front());
      exp_q.push_back(pend_e.pop_front());
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL test_reset_mdbusy cycle %0d: got %b expected %b", cyc, obs, want);
      end else $display("ok   test_reset_mdbusy cycle %0d: %b", cyc, obs);
      cyc++;
    end
  endtask

  initial begin
    stim_t s0;
    s0 = '0;
    s0.reset = 1'b1;
    apply(s0);
    test_reset();
    test_forwarding();
    test_load_use();
    test_mul_div();
    test_md_wait();
    test_mem_timeout();
    test_reset_mdbusy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
